// File: rtl/rf_wb_pkg.sv
//------------------------------------------------------------------------------
// Module  : rf_wb_pkg
// Purpose : Shared definitions for the register-file writeback arbiter.
//           Default widths, the architectural zero register index and the
//           grant-state type of the 2-input round-robin arbiter.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package rf_wb_pkg;

   localparam int        XLEN_DEF = 32;
   localparam int        AW_DEF   = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Encodes which requester received the most recent grant.
   typedef enum logic [0:0] {
      LAST0 = 1'b0,
      LAST1 = 1'b1
   } grant_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arb2.sv
//------------------------------------------------------------------------------
// Module  : rr_arb2
// Purpose : Two-input round-robin arbiter. A lone requester is always granted;
//           when both request, the one that did not win last is granted.
//           The last-grant state only moves on an actual grant.
// Ports   : clk     in   rising-edge clock
//           areset  in   asynchronous active-high reset (last grant = req1)
//           req     in   [1:0] request vector
//           gnt     out  [1:0] grant vector, one-hot or zero (combinational)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2
   import rf_wb_pkg::*;
(
   input  logic       clk,
   input  logic       areset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   grant_state_t r_state;
   grant_state_t w_state_nxt;

   // Reset to LAST1 so that req0 wins the first contested cycle.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state <= LAST1;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      gnt         = 2'b00;
      w_state_nxt = r_state;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (r_state == LAST0) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
      if (gnt[0]) begin
         w_state_nxt = LAST0;
      end else if (gnt[1]) begin
         w_state_nxt = LAST1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rf_wb_arbiter
// Purpose : Shares the register file's single write port between two
//           writeback requesters (req0 = ALU/jump, req1 = load/CSR).
//           Round-robin grant, one registered output stage (latency 1),
//           writes to x0 acknowledged but dropped, saturating counter of
//           cycles in which both requesters were valid.
// Config  : RF_WB_BYPASS_EN - adds a forwarding mux that returns the write
//           currently on the register-file port to the two read ports.
// Ports   : clk, areset                 clock / async active-high reset
//           req0_valid/addr/data/ready  requester 0 handshake
//           req1_valid/addr/data/ready  requester 1 handshake
//           rf_we, rf_waddr, rf_wdata   register-file write port (WE3/A3/WD3)
//           conflict_cnt                saturating both-valid cycle count
//           byp_a1/a2, byp_rd1/rd2      (bypass) reg_file read address/data
//           fwd_rd1/rd2                 (bypass) forwarded read data
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int AW    = AW_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             req0_valid,
   input  logic [AW-1:0]    req0_addr,
   input  logic [XLEN-1:0]  req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [AW-1:0]    req1_addr,
   input  logic [XLEN-1:0]  req1_data,
   output logic             req1_ready,
   output logic             rf_we,
   output logic [AW-1:0]    rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
`ifdef RF_WB_BYPASS_EN
   input  logic [AW-1:0]    byp_a1,
   input  logic [AW-1:0]    byp_a2,
   input  logic [XLEN-1:0]  byp_rd1,
   input  logic [XLEN-1:0]  byp_rd2,
   output logic [XLEN-1:0]  fwd_rd1,
   output logic [XLEN-1:0]  fwd_rd2,
`endif
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [AW-1:0]    c_zero_addr = AW'(REG_ZERO);
   localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

   logic [1:0]      w_req;
   logic [1:0]      w_gnt;
   logic            w_any_gnt;
   logic            w_write;
   logic [AW-1:0]   w_sel_addr;
   logic [XLEN-1:0] w_sel_data;
   logic            w_conflict;

   assign w_req = {req1_valid, req0_valid};

   rr_arb2 u_arb (
      .clk    (clk),
      .areset (areset),
      .req    (w_req),
      .gnt    (w_gnt)
   );

   assign req0_ready = w_gnt[0];
   assign req1_ready = w_gnt[1];

   assign w_sel_addr = w_gnt[1] ? req1_addr : req0_addr;
   assign w_sel_data = w_gnt[1] ? req1_data : req0_data;
   assign w_any_gnt  = |w_gnt;

   // A grant to x0 completes the handshake but never reaches the port.
   assign w_write    = w_any_gnt && (w_sel_addr != c_zero_addr);
   assign w_conflict = req0_valid && req1_valid;

   // Output stage: rewritten every cycle; address/data hold when no write
   // is issued so the port does not toggle needlessly.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= w_write;
         if (w_write) begin
            rf_waddr <= w_sel_addr;
            rf_wdata <= w_sel_data;
         end
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         conflict_cnt <= '0;
      end else if (w_conflict && (conflict_cnt != c_cnt_max)) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

`ifdef RF_WB_BYPASS_EN
   // Forward the write sitting on the port this cycle; x0 always reads the
   // register file value (which is zero).
   always_comb begin
      fwd_rd1 = byp_rd1;
      fwd_rd2 = byp_rd2;
      if (rf_we && (rf_waddr == byp_a1) && (byp_a1 != c_zero_addr)) begin
         fwd_rd1 = rf_wdata;
      end
      if (rf_we && (rf_waddr == byp_a2) && (byp_a2 != c_zero_addr)) begin
         fwd_rd2 = rf_wdata;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_rf_wb_arbiter
// Purpose : Self-checking bench for rf_wb_arbiter. A cycle model tracks the
//           round-robin winner, the pending port write and the conflict
//           count; directed sequences add literal expectations.
// Config  : RF_WB_BYPASS_EN - also exercises the forwarding outputs.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rf_wb_arbiter;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            areset;
   logic            req0_valid, req1_valid;
   logic [AW-1:0]   req0_addr, req1_addr;
   logic [XLEN-1:0] req0_data, req1_data;
   logic            req0_ready, req1_ready;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [15:0]     conflict_cnt;

   // Second instance with a 4-bit counter, both requesters always valid.
   logic            d2_v = 1'b1;
   logic [AW-1:0]   d2_addr = 5'd1;
   logic [XLEN-1:0] d2_data = 32'h0;
   logic            d2_rdy0, d2_rdy1, d2_we;
   logic [AW-1:0]   d2_waddr;
   logic [XLEN-1:0] d2_wdata;
   logic [3:0]      d2_cnt;

`ifdef RF_WB_BYPASS_EN
   logic [AW-1:0]   byp_a1, byp_a2;
   logic [XLEN-1:0] byp_rd1, byp_rd2, fwd_rd1, fwd_rd2;
   logic [XLEN-1:0] d2_fwd1, d2_fwd2;
`endif

   always #5 clk = ~clk;

   rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .CNT_W(16)) dut (
      .clk(clk), .areset(areset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef RF_WB_BYPASS_EN
      .byp_a1(byp_a1), .byp_a2(byp_a2), .byp_rd1(byp_rd1), .byp_rd2(byp_rd2),
      .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2),
`endif
      .conflict_cnt(conflict_cnt)
   );

   rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .CNT_W(4)) dut2 (
      .clk(clk), .areset(areset),
      .req0_valid(d2_v), .req0_addr(d2_addr), .req0_data(d2_data), .req0_ready(d2_rdy0),
      .req1_valid(d2_v), .req1_addr(d2_addr), .req1_data(d2_data), .req1_ready(d2_rdy1),
      .rf_we(d2_we), .rf_waddr(d2_waddr), .rf_wdata(d2_wdata),
`ifdef RF_WB_BYPASS_EN
      .byp_a1(byp_a1), .byp_a2(byp_a2), .byp_rd1(byp_rd1), .byp_rd2(byp_rd2),
      .fwd_rd1(d2_fwd1), .fwd_rd2(d2_fwd2),
`endif
      .conflict_cnt(d2_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int              m_last;     // index of the requester granted most recently
   bit              m_we;
   logic [AW-1:0]   m_addr;
   logic [XLEN-1:0] m_data;
   int              m_cnt;
   int              m2_cnt;

   function automatic int winner(input bit v0, input bit v1, input int last);
      if (v0 && v1) return (last == 0) ? 1 : 0;
      if (v0)       return 0;
      if (v1)       return 1;
      return -1;
   endfunction

   always @(posedge clk or posedge areset) begin
      if (areset) begin
         m_last = 1; m_we = 0; m_addr = '0; m_data = '0; m_cnt = 0; m2_cnt = 0;
      end else begin
         int w;
         w = winner(req0_valid, req1_valid, m_last);
         m_we = 0;
         if (w >= 0) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] d;
            a = (w == 0) ? req0_addr : req1_addr;
            d = (w == 0) ? req0_data : req1_data;
            m_last = w;
            if (a != 0) begin
               m_we = 1; m_addr = a; m_data = d;
            end
         end
         if (req0_valid && req1_valid && m_cnt < 65535) m_cnt++;
         if (m2_cnt < 15) m2_cnt++;
      end
   end

   // Compare process: every cycle outside reset.
   always @(negedge clk) begin
      if (!areset) begin
         int w;
         w = winner(req0_valid, req1_valid, m_last);
         chk("ready0", req0_ready, (w == 0));
         chk("ready1", req1_ready, (w == 1));
         chk("rf_we", rf_we, m_we);
         if (m_we) begin
            chk("rf_waddr", rf_waddr, m_addr);
            chk("rf_wdata", rf_wdata, m_data);
         end
         chk("conflict_cnt", conflict_cnt, m_cnt);
         chk("cnt4", d2_cnt, m2_cnt);
`ifdef RF_WB_BYPASS_EN
         chk("fwd_rd1", fwd_rd1, (m_we && m_addr == byp_a1 && byp_a1 != 0) ? m_data : byp_rd1);
         chk("fwd_rd2", fwd_rd2, (m_we && m_addr == byp_a2 && byp_a2 != 0) ? m_data : byp_rd2);
`endif
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_reset();
      areset = 1'b1;
      @(posedge clk); #1;
      areset = 1'b0;
   endtask

   // Pattern table for mixed traffic: raise bits and addresses per step.
   logic [1:0]    pat_raise [8] = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01};
   logic [AW-1:0] pat_a0    [8] = '{5'd4, 5'd0, 5'd4, 5'd2, 5'd31, 5'd6, 5'd0, 5'd8};
   logic [AW-1:0] pat_a1    [8] = '{5'd4, 5'd9, 5'd0, 5'd12, 5'd31, 5'd6, 5'd17, 5'd3};

   initial begin
      int         g [4];
      logic       r0, r1;
      areset = 1'b1;
      req0_valid = 0; req1_valid = 0;
      req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
`ifdef RF_WB_BYPASS_EN
      byp_a1 = '0; byp_a2 = '0; byp_rd1 = '0; byp_rd2 = 32'h2222_2222;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_we", rf_we, 1'b0);
      chk("rst_waddr", rf_waddr, 5'd0);
      chk("rst_wdata", rf_wdata, 32'h0);
      chk("rst_cnt", conflict_cnt, 16'd0);
      @(posedge clk); #1 areset = 1'b0;

      // 1: single write, latency one cycle
      req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("t1_ready0", req0_ready, 1'b1);
      @(posedge clk); #1 req0_valid = 0;
      @(negedge clk);
      chk("t1_we", rf_we, 1'b1);
      chk("t1_waddr", rf_waddr, 5'd5);
      chk("t1_wdata", rf_wdata, 32'hDEADBEEF);

      // 2: both valid for 4 cycles from reset -> alternating grants
      do_reset();
      req0_valid = 1; req0_addr = 5'd10; req0_data = 32'h100;
      req1_valid = 1; req1_addr = 5'd11; req1_data = 32'h200;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         r0 = req0_ready; r1 = req1_ready;
         g[i] = r1 ? 1 : (r0 ? 0 : -1);
         @(posedge clk); #1;
         if (r0) req0_data = req0_data + 1;
         if (r1) req1_data = req1_data + 1;
      end
      req0_valid = 0; req1_valid = 0;
      chk("t2_g0", g[0], 0);
      chk("t2_g1", g[1], 1);
      chk("t2_g2", g[2], 0);
      chk("t2_g3", g[3], 1);
      @(negedge clk);
      chk("t2_cnt", conflict_cnt, 16'd4);

      // 3: x0 write acknowledged, dropped, still counts for round-robin
      do_reset();
      req1_valid = 1; req1_addr = 5'd0; req1_data = 32'h1234;
      @(negedge clk);
      chk("t3_ready1", req1_ready, 1'b1);
      @(posedge clk); #1 req1_valid = 0;
      @(negedge clk);
      chk("t3_we", rf_we, 1'b0);
      @(posedge clk); #1;
      req0_valid = 1; req0_addr = 5'd9;  req0_data = 32'h99;
      req1_valid = 1; req1_addr = 5'd10; req1_data = 32'hAA;
      @(negedge clk);
      chk("t3_both_r0", req0_ready, 1'b1);
      chk("t3_both_r1", req1_ready, 1'b0);
      @(posedge clk); #1 req0_valid = 0;
      @(posedge clk); #1 req1_valid = 0;

      // 4: async reset discards a pending write to addr 7
      @(posedge clk); #1;
      req0_valid = 1; req0_addr = 5'd7; req0_data = 32'h77;
      @(posedge clk); #1 req0_valid = 0;
      #2 chk("t4_pre_we", rf_we, 1'b1);
      areset = 1'b1;
      #1;
      chk("t4_we", rf_we, 1'b0);
      chk("t4_waddr", rf_waddr, 5'd0);
      chk("t4_cnt", conflict_cnt, 16'd0);
      @(posedge clk); #1 areset = 1'b0;

      // 5: 4-bit counter saturates at 15 after 20 contested cycles
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t5_cnt4", d2_cnt, 4'd15);

      // Mixed traffic incl. same-address and x0; requesters hold until ready.
      for (int i = 0; i < 8; i++) begin
         if (!req0_valid && pat_raise[i][0]) begin
            req0_valid = 1; req0_addr = pat_a0[i]; req0_data = 32'hA000_0000 + i;
         end
         if (!req1_valid && pat_raise[i][1]) begin
            req1_valid = 1; req1_addr = pat_a1[i]; req1_data = 32'hB000_0000 + i;
         end
         @(negedge clk);
         r0 = req0_ready; r1 = req1_ready;
         @(posedge clk); #1;
         if (r0) req0_valid = 0;
         if (r1) req1_valid = 0;
      end
      repeat (3) begin
         @(negedge clk);
         r0 = req0_ready; r1 = req1_ready;
         @(posedge clk); #1;
         if (r0) req0_valid = 0;
         if (r1) req1_valid = 0;
      end

`ifdef RF_WB_BYPASS_EN
      // 6: forward the write on the port to read port 1
      req0_valid = 1; req0_addr = 5'd3; req0_data = 32'hA5A5A5A5;
      @(posedge clk); #1;
      req0_valid = 0; byp_a1 = 5'd3; byp_rd1 = 32'h0;
      #1 chk("t6_fwd", fwd_rd1, 32'hA5A5A5A5);
      byp_a1 = 5'd0; byp_rd1 = 32'h1111_1111;
      #1 chk("t6_nofwd", fwd_rd1, 32'h1111_1111);
      @(posedge clk); #1;
`endif

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
